// File: rtl/dds_pport_engine.sv
// Byte-level transfer engine for the DDS parallel port: one command in, one CSn-framed
// address + data burst out, optional IO_UPDATE strobe, one-cycle response pulse.
module dds_pport_engine #(
    parameter int CLK_DIV  = 2,
    parameter int IOUP_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    // Handshake: a command transfers on the rising edge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE, cmd_valid is ignored otherwise.
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rw,
    input  logic [1:0]  cmd_nbytes,
    input  logic [7:0]  cmd_addr,
    input  logic [23:0] cmd_wdata,
    input  logic        cmd_ioup,
    output logic        rsp_valid,
    output logic [23:0] rsp_rdata,
    output logic        busy,
    output logic        DDS_PCLK,
    output logic        DDS_CSn,
    output logic        DDS_RWn,
    output logic        DDS_ReadEn,
    output logic [7:0]  DDS_DataOut,
    input  logic [7:0]  DDS_DataIn,
    output logic        DDS_IOup
);

    typedef enum logic [2:0] {
        S_RESET, S_IDLE, S_SETUP, S_ADDR, S_DATA, S_HOLD, S_IOUP, S_DONE
    } state_t;

    localparam logic [8:0] HALF_LEN = 9'(CLK_DIV);
    localparam logic [8:0] SLOT_LEN = 9'(2 * CLK_DIV);
    localparam logic [8:0] IOUP_LEN = 9'(IOUP_CYC);

    state_t      state, state_nx;
    logic [8:0]  cnt;
    logic [8:0]  phase_len;
    logic        phase_last;
    logic [1:0]  bytes_left;
    logic        rw_q;
    logic        ioup_q;
    logic [7:0]  addr_q;
    logic [23:0] wdata_q;
    logic [23:0] shift_q;
    logic [7:0]  wr_byte;
    logic        accept;

    assign accept = (state == S_IDLE) && cmd_valid;

    always_comb begin
        phase_len = 9'd1;
        case (state)
            S_SETUP, S_HOLD: phase_len = HALF_LEN;
            S_ADDR, S_DATA:  phase_len = SLOT_LEN;
            S_IOUP:          phase_len = IOUP_LEN;
            default:         phase_len = 9'd1;
        endcase
    end

    assign phase_last = (cnt == phase_len - 9'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_RESET;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_RESET: state_nx = S_IDLE;
            S_IDLE:  if (cmd_valid) state_nx = S_SETUP;
            S_SETUP: if (phase_last) state_nx = S_ADDR;
            S_ADDR:  if (phase_last) state_nx = S_DATA;
            S_DATA:  if (phase_last && bytes_left == 2'd1) state_nx = S_HOLD;
            S_HOLD:  if (phase_last) state_nx = (!rw_q && ioup_q) ? S_IOUP : S_DONE;
            S_IOUP:  if (phase_last) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Phase counter restarts at every state change and at every byte-slot boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= 9'd0;
            bytes_left <= 2'd0;
            rw_q       <= 1'b0;
            ioup_q     <= 1'b0;
            addr_q     <= 8'd0;
            wdata_q    <= 24'd0;
            shift_q    <= 24'd0;
            rsp_rdata  <= 24'd0;
        end else begin
            if (state_nx != state || phase_last) cnt <= 9'd0;
            else                                 cnt <= cnt + 9'd1;

            if (accept) begin
                rw_q       <= cmd_rw;
                ioup_q     <= cmd_ioup;
                addr_q     <= cmd_addr;
                wdata_q    <= cmd_wdata;
                bytes_left <= (cmd_nbytes == 2'd0) ? 2'd1 : cmd_nbytes;
                shift_q    <= 24'd0;
            end

            if (state == S_DATA && phase_last) begin
                bytes_left <= bytes_left - 2'd1;
                if (rw_q) shift_q <= {shift_q[15:0], DDS_DataIn};
            end

            if (state == S_HOLD && phase_last && rw_q) rsp_rdata <= shift_q;
        end
    end

    // bytes_left counts down, so the MSB-first byte order falls out of the index.
    always_comb begin
        case (bytes_left)
            2'd3:    wr_byte = wdata_q[23:16];
            2'd2:    wr_byte = wdata_q[15:8];
            default: wr_byte = wdata_q[7:0];
        endcase
    end

    always_comb begin
        cmd_ready   = (state == S_IDLE);
        busy        = (state != S_IDLE);
        rsp_valid   = (state == S_DONE);
        DDS_CSn     = 1'b1;
        DDS_RWn     = 1'b1;
        DDS_PCLK    = 1'b0;
        DDS_ReadEn  = 1'b0;
        DDS_DataOut = 8'd0;
        DDS_IOup    = 1'b0;
        case (state)
            S_SETUP: begin
                DDS_CSn = 1'b0;
                DDS_RWn = 1'b0;
            end
            S_ADDR: begin
                DDS_CSn     = 1'b0;
                DDS_RWn     = 1'b0;
                DDS_PCLK    = (cnt >= HALF_LEN);
                DDS_DataOut = addr_q;
            end
            S_DATA: begin
                DDS_CSn     = 1'b0;
                DDS_RWn     = rw_q;
                DDS_ReadEn  = rw_q;
                DDS_PCLK    = (cnt >= HALF_LEN);
                DDS_DataOut = rw_q ? 8'd0 : wr_byte;
            end
            S_HOLD:  DDS_CSn  = 1'b0;
            S_IOUP:  DDS_IOup = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dds_pport_engine.sv
// Bench for dds_pport_engine: two instances (default and CLK_DIV=1/IOUP_CYC=1) checked cycle by
// cycle against a per-transfer expected waveform built from the phase rules.
module tb_dds_pport_engine;

    typedef struct packed {
        logic       csn;
        logic       rwn;
        logic       pclk;
        logic       readen;
        logic       ioup;
        logic       rsp;
        logic       dchk;
        logic       samp;
        logic [7:0] dout;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cvalid;
    logic        c_rw;
    logic [1:0]  c_nb;
    logic [7:0]  c_addr;
    logic [23:0] c_wdata;
    logic        c_io;
    logic [7:0]  din;

    logic [1:0]  ready, busy, rspv, pclk, csn, rwn, re, io;
    logic [7:0]  dout [2];
    logic [23:0] rdata [2];

    exp_t        exp_q[$];
    logic [23:0] last_rd [2];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    dds_pport_engine #(.CLK_DIV(2), .IOUP_CYC(4)) dut0 (
        .clk(clk), .rst(rst), .cmd_valid(cvalid[0]), .cmd_ready(ready[0]),
        .cmd_rw(c_rw), .cmd_nbytes(c_nb), .cmd_addr(c_addr), .cmd_wdata(c_wdata),
        .cmd_ioup(c_io), .rsp_valid(rspv[0]), .rsp_rdata(rdata[0]), .busy(busy[0]),
        .DDS_PCLK(pclk[0]), .DDS_CSn(csn[0]), .DDS_RWn(rwn[0]), .DDS_ReadEn(re[0]),
        .DDS_DataOut(dout[0]), .DDS_DataIn(din), .DDS_IOup(io[0])
    );

    dds_pport_engine #(.CLK_DIV(1), .IOUP_CYC(1)) dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cvalid[1]), .cmd_ready(ready[1]),
        .cmd_rw(c_rw), .cmd_nbytes(c_nb), .cmd_addr(c_addr), .cmd_wdata(c_wdata),
        .cmd_ioup(c_io), .rsp_valid(rspv[1]), .rsp_rdata(rdata[1]), .busy(busy[1]),
        .DDS_PCLK(pclk[1]), .DDS_CSn(csn[1]), .DDS_RWn(rwn[1]), .DDS_ReadEn(re[1]),
        .DDS_DataOut(dout[1]), .DDS_DataIn(din), .DDS_IOup(io[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic csn_v, input logic rwn_v, input logic pclk_v,
                                input logic re_v, input logic io_v, input logic rsp_v,
                                input logic dchk_v, input logic samp_v, input logic [7:0] d);
        exp_t e;
        e = {csn_v, rwn_v, pclk_v, re_v, io_v, rsp_v, dchk_v, samp_v, d};
        return e;
    endfunction

    // Expected waveform from the acceptance edge onward, one entry per clk cycle.
    function automatic void build(input int cd, input int ic, input logic rw, input logic [1:0] nb,
                                  input logic [7:0] addr, input logic [23:0] wdata, input logic iou);
        int n;
        logic [7:0] by;
        logic rd;
        n = (nb == 2'd0) ? 1 : int'(nb);
        exp_q.delete();
        for (int c = 0; c < cd; c++) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 8'h00));
        for (int s = 0; s <= n; s++) begin
            rd = (s > 0) && rw;
            if (s == 0)  by = addr;
            else if (rw) by = 8'h00;
            else         by = 8'(wdata >> (8 * (n - s)));
            for (int c = 0; c < 2 * cd; c++)
                exp_q.push_back(mk(0, rd, c >= cd, rd, 0, 0, 1, rd && (c == 2 * cd - 1), by));
        end
        for (int c = 0; c < cd; c++) exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 8'h00));
        if (!rw && iou)
            for (int c = 0; c < ic; c++) exp_q.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 8'h00));
        exp_q.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 8'h00));
    endfunction

    task automatic do_xfer(input int sel, input logic rw, input logic [1:0] nb,
                           input logic [7:0] addr, input logic [23:0] wdata, input logic iou,
                           input bit fix55, input bit hold_next,
                           output int csn_low, output int io_cnt, output int lat,
                           output int pulses, output logic [31:0] seq);
        int w;
        logic [23:0] r;
        logic [7:0] b;
        logic prev_pclk;
        logic [15:0] ov, ev;
        exp_t e;
        c_rw = rw; c_nb = nb; c_addr = addr; c_wdata = wdata; c_io = iou;
        cvalid[sel] = 1'b1;
        w = 0;
        while (!ready[sel] && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("accept_ready", 32'(ready[sel]), 32'd1);
        @(posedge clk);
        #1;
        if (!hold_next) cvalid[sel] = 1'b0;
        build(sel ? 1 : 2, sel ? 1 : 4, rw, nb, addr, wdata, iou);
        r = 24'd0; csn_low = 0; io_cnt = 0; lat = 0; pulses = 0; seq = 32'd0; prev_pclk = 1'b0;
        @(negedge clk);
        foreach (exp_q[j]) begin
            e = exp_q[j];
            if (e.samp) begin
                b = fix55 ? 8'h55 : 8'($urandom);
                r = {r[15:0], b};
                din = b;
            end else begin
                din = 8'($urandom);
            end
            if (hold_next) begin
                c_rw = 1'($urandom); c_nb = 2'($urandom_range(0, 3));
                c_addr = 8'($urandom); c_wdata = 24'($urandom); c_io = 1'($urandom);
            end
            ov = {ready[sel], busy[sel], rspv[sel], csn[sel], rwn[sel], pclk[sel], re[sel],
                  io[sel], e.dchk ? dout[sel] : 8'h00};
            ev = {1'b0, 1'b1, e.rsp, e.csn, e.rwn, e.pclk, e.readen, e.ioup,
                  e.dchk ? e.dout : 8'h00};
            chk($sformatf("cyc%0d_dut%0d", j, sel), 32'(ov), 32'(ev));
            if (csn[sel] === 1'b0) csn_low++;
            if (io[sel] === 1'b1) io_cnt++;
            if (pclk[sel] === 1'b1 && !prev_pclk) begin
                pulses++;
                seq = {seq[23:0], dout[sel]};
            end
            prev_pclk = (pclk[sel] === 1'b1);
            if (rspv[sel] === 1'b1) lat = j + 1;
            if (e.rsp) begin
                if (rw) last_rd[sel] = r;
                chk("rsp_rdata", 32'(rdata[sel]), 32'(last_rd[sel]));
            end
            @(negedge clk);
        end
        chk("idle_after", 32'({ready[sel], busy[sel], rspv[sel], csn[sel], pclk[sel], io[sel]}),
            32'(6'b100100));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, b2, lt, pc, w;
        logic [31:0] sq;
        rst = 1'b1; cvalid = 2'b00; c_rw = 0; c_nb = 0; c_addr = 0; c_wdata = 0; c_io = 0;
        din = 8'h00; last_rd[0] = 24'd0; last_rd[1] = 24'd0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset_outputs", 32'({ready[i], busy[i], rspv[i], csn[i], rwn[i], pclk[i], re[i],
                io[i], dout[i]}), 32'({8'b01011000, 8'h00}));
            chk("reset_rdata", 32'(rdata[i]), 32'd0);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_low_at_release", 32'(ready), 32'd0);
        @(negedge clk);
        chk("ready_after_release", 32'(ready), 32'd3);

        // Reference write: 3 bytes with IO_UPDATE
        do_xfer(0, 0, 2'd3, 8'h04, 24'h120514, 1, 0, 0, a, b2, lt, pc, sq);
        chk("wr_csn_low", 32'(a), 32'd20);
        chk("wr_ioup_len", 32'(b2), 32'd4);
        chk("wr_latency", 32'(lt), 32'd25);
        chk("wr_pulses", 32'(pc), 32'd4);
        chk("wr_bytes", sq, 32'h04120514);

        // Read with ioup set: IO_UPDATE must not fire
        do_xfer(0, 1, 2'd2, 8'h84, 24'hABCDEF, 1, 1, 0, a, b2, lt, pc, sq);
        chk("rd_rdata", 32'(rdata[0]), 32'h005555);
        chk("rd_no_ioup", 32'(b2), 32'd0);
        chk("rd_latency", 32'(lt), 32'd17);
        chk("rd_pulses", 32'(pc), 32'd3);

        // nbytes=0 behaves like nbytes=1
        do_xfer(0, 0, 2'd0, 8'h3C, 24'h0000A7, 0, 0, 0, a, b2, lt, pc, sq);
        chk("nb0_pulses", 32'(pc), 32'd2);
        chk("nb0_csn_low", 32'(a), 32'd12);
        chk("nb0_bytes", sq, 32'h00003CA7);
        do_xfer(0, 0, 2'd1, 8'h3C, 24'h0000A7, 0, 0, 0, a, b2, lt, pc, sq);
        chk("nb1_csn_low", 32'(a), 32'd12);
        chk("nb1_bytes", sq, 32'h00003CA7);

        // cmd_valid held with changing fields; next command taken the cycle after DONE
        do_xfer(0, 0, 2'd2, 8'h11, 24'h00BEEF, 0, 0, 1, a, b2, lt, pc, sq);
        do_xfer(0, 1, 2'd1, 8'h91, 24'h000000, 0, 0, 0, a, b2, lt, pc, sq);
        chk("b2b_latency", 32'(lt), 32'd13);

        for (int k = 0; k < 12; k++) begin
            do_xfer(0, 1'($urandom), 2'($urandom_range(0, 3)), 8'($urandom), 24'($urandom),
                    1'($urandom), 0, 0, a, b2, lt, pc, sq);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Asynchronous reset in the middle of a DATA slot's high phase
        c_rw = 0; c_nb = 2'd3; c_addr = 8'h40; c_wdata = 24'h123456; c_io = 1;
        cvalid[0] = 1'b1;
        w = 0;
        while (!ready[0] && w < 200) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1 cvalid[0] = 1'b0;
        @(negedge clk);
        repeat (8) @(negedge clk);
        chk("pre_rst_state", 32'({csn[0], pclk[0]}), 32'(2'b01));
        #2 rst = 1'b1;
        #1;
        chk("rst_async", 32'({ready[0], busy[0], rspv[0], csn[0], pclk[0], io[0], re[0]}),
            32'(7'b0101000));
        @(negedge clk);
        rst = 1'b0;
        last_rd[0] = 24'd0; last_rd[1] = 24'd0;
        #1;
        chk("rst_ready_low", 32'(ready[0]), 32'd0);
        @(negedge clk);
        chk("rst_ready_high", 32'(ready[0]), 32'd1);
        chk("rst_rdata", 32'(rdata[0]), 32'd0);
        for (int k = 0; k < 30; k++) begin
            chk("no_rsp_after_abort", 32'({rspv[0], io[0], csn[0]}), 32'(3'b001));
            @(negedge clk);
        end

        // Fast instance: CLK_DIV=1, IOUP_CYC=1
        do_xfer(1, 0, 2'd1, 8'h22, 24'h00005A, 1, 0, 0, a, b2, lt, pc, sq);
        chk("fast_csn_low", 32'(a), 32'd6);
        chk("fast_ioup_len", 32'(b2), 32'd1);
        chk("fast_latency", 32'(lt), 32'd8);
        chk("fast_pulses", 32'(pc), 32'd2);
        chk("fast_bytes", sq, 32'h0000225A);
        for (int k = 0; k < 6; k++) begin
            do_xfer(1, 1'($urandom), 2'($urandom_range(0, 3)), 8'($urandom), 24'($urandom),
                    1'($urandom), 0, 0, a, b2, lt, pc, sq);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
